// File: rtl/spi_slave.sv
// SPI responder: oversamples sck/cs/mosi in the clk domain, receives one
// DATA_WIDTH word per cs-low frame and returns a preloaded word on miso.
// Ports:
//   clk, rst_n                  system clock, synchronous active-low reset
//   sck, cs, mosi               asynchronous SPI pins from the master
//   miso                        registered slave-out data
//   tx_data, tx_valid, tx_ready response word handshake (one-word holding reg)
//   rx_data, rx_valid           last complete word, one-cycle update pulse
//   busy                        synchronised cs is low and a frame is open
//   underrun                    one-cycle pulse: frame began with no tx word
module spi_slave #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned MODE       = 0,
    parameter bit          LSB_FIRST  = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  sck,
    input  logic                  cs,
    input  logic                  mosi,
    output logic                  miso,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    output logic                  busy,
    output logic                  underrun
);

    localparam logic CPOL     = (MODE & 2) != 0;
    localparam logic CPHA     = (MODE & 1) != 0;
    localparam logic SMP_RISE = (CPOL == CPHA);
    localparam int   CW       = $clog2(DATA_WIDTH + 1);

    typedef enum logic [1:0] {IDLE, ACTIVE, DONE} state_t;

    state_t                state_q;
    logic                  sck_s1_q, sck_s2_q, sck_s3_q;
    logic                  cs_s1_q, cs_s2_q, cs_s3_q;
    logic                  mosi_s1_q, mosi_s2_q, mosi_s3_q;
    logic [1:0]            fill_q;
    logic                  armed_q;
    logic [DATA_WIDTH-1:0] hold_q;
    logic                  hold_full_q;
    logic [DATA_WIDTH-1:0] tx_sr_q;
    logic [DATA_WIDTH-1:0] rx_sr_q;
    logic [CW-1:0]         cnt_q;
    logic                  finish_q;
    logic                  miso_q;
    logic [DATA_WIDTH-1:0] rx_data_q;
    logic                  rx_valid_q;
    logic                  busy_q;
    logic                  underrun_q;

    logic                  sck_rise, sck_fall, smp_edge, shf_edge;
    logic                  cs_fall, cs_rise;
    logic [DATA_WIDTH-1:0] load_d, rx_sr_d;

    function automatic logic out_bit(input logic [DATA_WIDTH-1:0] w);
        return LSB_FIRST ? w[0] : w[DATA_WIDTH-1];
    endfunction

    function automatic logic [DATA_WIDTH-1:0] adv(
        input logic [DATA_WIDTH-1:0] w
    );
        return LSB_FIRST ? (w >> 1) : (w << 1);
    endfunction

    assign sck_rise = sck_s2_q & ~sck_s3_q;
    assign sck_fall = ~sck_s2_q & sck_s3_q;
    assign smp_edge = SMP_RISE ? sck_rise : sck_fall;
    assign shf_edge = SMP_RISE ? sck_fall : sck_rise;
    // A fall only counts once cs has genuinely been seen high since reset,
    // so a reset in the middle of a frame cannot start a bogus frame.
    assign cs_fall  = armed_q & ~cs_s2_q & cs_s3_q;
    assign cs_rise  = cs_s2_q & ~cs_s3_q;
    assign load_d   = hold_full_q ? hold_q : '0;
    assign rx_sr_d  = LSB_FIRST
                    ? {mosi_s3_q, rx_sr_q[DATA_WIDTH-1:1]}
                    : {rx_sr_q[DATA_WIDTH-2:0], mosi_s3_q};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            sck_s1_q    <= CPOL;
            sck_s2_q    <= CPOL;
            sck_s3_q    <= CPOL;
            cs_s1_q     <= 1'b1;
            cs_s2_q     <= 1'b1;
            cs_s3_q     <= 1'b1;
            mosi_s1_q   <= 1'b0;
            mosi_s2_q   <= 1'b0;
            mosi_s3_q   <= 1'b0;
            fill_q      <= '0;
            armed_q     <= 1'b0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            tx_sr_q     <= '0;
            rx_sr_q     <= '0;
            cnt_q       <= '0;
            finish_q    <= 1'b0;
            miso_q      <= 1'b0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            busy_q      <= 1'b0;
            underrun_q  <= 1'b0;
        end else begin
            sck_s1_q  <= sck;
            sck_s2_q  <= sck_s1_q;
            sck_s3_q  <= sck_s2_q;
            cs_s1_q   <= cs;
            cs_s2_q   <= cs_s1_q;
            cs_s3_q   <= cs_s2_q;
            mosi_s1_q <= mosi;
            mosi_s2_q <= mosi_s1_q;
            mosi_s3_q <= mosi_s2_q;

            // Stage 3 holds a real pin sample once three clocks have passed.
            if (fill_q != 2'd3) begin
                fill_q <= fill_q + 2'd1;
            end
            if (fill_q == 2'd3 && cs_s3_q) begin
                armed_q <= 1'b1;
            end

            rx_valid_q <= 1'b0;
            underrun_q <= 1'b0;

            if (tx_valid && !hold_full_q) begin
                hold_q      <= tx_data;
                hold_full_q <= 1'b1;
            end

            if (finish_q) begin
                rx_data_q  <= rx_sr_q;
                rx_valid_q <= 1'b1;
                finish_q   <= 1'b0;
            end

            unique case (state_q)
                IDLE: begin
                    miso_q <= 1'b0;
                    cnt_q  <= '0;
                    if (cs_fall) begin
                        state_q <= ACTIVE;
                        busy_q  <= 1'b1;
                        if (hold_full_q) begin
                            hold_full_q <= 1'b0;
                        end else begin
                            underrun_q <= 1'b1;
                        end
                        // CPHA=0 presents bit 0 before the first sck edge.
                        if (CPHA) begin
                            tx_sr_q <= load_d;
                        end else begin
                            miso_q  <= out_bit(load_d);
                            tx_sr_q <= adv(load_d);
                        end
                    end
                end
                ACTIVE: begin
                    if (cs_rise) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        miso_q  <= 1'b0;
                        cnt_q   <= '0;
                    end else if (smp_edge) begin
                        rx_sr_q <= rx_sr_d;
                        cnt_q   <= cnt_q + 1'b1;
                        if (cnt_q == CW'(DATA_WIDTH - 1)) begin
                            state_q  <= DONE;
                            finish_q <= 1'b1;
                            miso_q   <= 1'b0;
                        end
                    end else if (shf_edge) begin
                        miso_q  <= out_bit(tx_sr_q);
                        tx_sr_q <= adv(tx_sr_q);
                    end
                end
                DONE: begin
                    miso_q <= 1'b0;
                    if (cs_rise) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        cnt_q   <= '0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign miso     = miso_q;
    assign tx_ready = ~hold_full_q;
    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;
    assign busy     = busy_q;
    assign underrun = underrun_q;

endmodule

// File: tb/tb_spi_slave.sv
// Bench for spi_slave: five instances (modes 0..3 MSB-first, mode 0
// LSB-first) driven by a behavioural SPI master and a word-level model.
module tb_spi_slave;

    localparam int W    = 12;
    localparam int N    = 5;
    localparam int HALF = 50;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [N-1:0] sck, cs, mosi, miso;
    logic [N-1:0] tx_valid, tx_ready, rx_valid, busy, underrun;
    logic [W-1:0] tx_data [N];
    logic [W-1:0] rx_data [N];

    int passed = 0;
    int total  = 0;
    int rxv_cnt [N];
    int unr_cnt [N];

    // Word-level reference: one holding slot per device and last rx word.
    bit           m_full [N];
    logic [W-1:0] m_hold [N];
    logic [W-1:0] m_rx   [N];

    for (genvar g = 0; g < N; g++) begin : g_dut
        spi_slave #(
            .DATA_WIDTH(W),
            .MODE      (g % 4),
            .LSB_FIRST (g == 4)
        ) u_dut (
            .clk     (clk),
            .rst_n   (rst_n),
            .sck     (sck[g]),
            .cs      (cs[g]),
            .mosi    (mosi[g]),
            .miso    (miso[g]),
            .tx_data (tx_data[g]),
            .tx_valid(tx_valid[g]),
            .tx_ready(tx_ready[g]),
            .rx_data (rx_data[g]),
            .rx_valid(rx_valid[g]),
            .busy    (busy[g]),
            .underrun(underrun[g])
        );
    end

    always @(posedge clk) begin
        for (int k = 0; k < N; k++) begin
            if (rx_valid[k] === 1'b1) rxv_cnt[k]++;
            if (underrun[k] === 1'b1) unr_cnt[k]++;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    function automatic logic bitof(input logic [W-1:0] w, input int i,
                                   input bit lsb);
        return lsb ? w[i] : w[W-1-i];
    endfunction

    task automatic check_reset_vals(input int k, input string when);
        check($sformatf("%s_miso_%0d", when, k), 32'(miso[k]), 0);
        check($sformatf("%s_txrdy_%0d", when, k), 32'(tx_ready[k]), 1);
        check($sformatf("%s_rxdata_%0d", when, k), 32'(rx_data[k]), 0);
        check($sformatf("%s_rxv_%0d", when, k), 32'(rx_valid[k]), 0);
        check($sformatf("%s_busy_%0d", when, k), 32'(busy[k]), 0);
        check($sformatf("%s_unr_%0d", when, k), 32'(underrun[k]), 0);
    endtask

    task automatic push(input int k, input logic [W-1:0] d);
        check($sformatf("txrdy_pre_%0d", k), 32'(tx_ready[k]),
              32'(!m_full[k]));
        @(negedge clk);
        tx_data[k]  = d;
        tx_valid[k] = 1'b1;
        @(negedge clk);
        tx_valid[k] = 1'b0;
        if (!m_full[k]) begin
            m_full[k] = 1'b1;
            m_hold[k] = d;
        end
        check($sformatf("txrdy_post_%0d", k), 32'(tx_ready[k]),
              32'(!m_full[k]));
    endtask

    task automatic frame(input int k, input logic [W-1:0] mo,
                         input int nbits, input bit do_rst);
        logic       cp, ch, lsb, exp_unr;
        logic [W-1:0] sin, exp_miso;
        int         rv0, un0, idx;
        cp       = ((k % 4) / 2) != 0;
        ch       = (k % 2) != 0;
        lsb      = (k == 4);
        exp_unr  = !m_full[k];
        exp_miso = m_full[k] ? m_hold[k] : '0;
        m_full[k] = 1'b0;
        rv0 = rxv_cnt[k];
        un0 = unr_cnt[k];
        sin = '0;
        cs[k] = 1'b0;
        if (!ch) mosi[k] = bitof(mo, 0, lsb);
        #100;
        check($sformatf("busy_on_%0d", k), 32'(busy[k]), 1);
        check($sformatf("txrdy_start_%0d", k), 32'(tx_ready[k]), 1);
        for (int i = 0; i < W; i++) begin
            if (!do_rst && i >= nbits) break;
            if (do_rst && i == 6) begin
                @(negedge clk);
                rst_n = 1'b0;
                @(negedge clk);
                check_reset_vals(k, "midrst");
                @(negedge clk);
                rst_n = 1'b1;
                for (int j = 0; j < N; j++) begin
                    m_full[j] = 1'b0;
                    m_rx[j]   = '0;
                end
            end
            idx = lsb ? i : W - 1 - i;
            if (!ch) mosi[k] = bitof(mo, i, lsb);
            #HALF;
            sck[k] = ~cp;
            if (!ch) sin[idx] = miso[k];
            else     mosi[k]  = bitof(mo, i, lsb);
            #HALF;
            sck[k] = cp;
            if (ch) sin[idx] = miso[k];
        end
        #(2 * HALF);
        cs[k]   = 1'b1;
        mosi[k] = 1'b0;
        #200;
        if (do_rst || nbits < W) begin
            check($sformatf("part_rxv_%0d", k), 32'(rxv_cnt[k] - rv0), 0);
            check($sformatf("part_rxdata_%0d", k), 32'(rx_data[k]),
                  32'(m_rx[k]));
        end else begin
            m_rx[k] = mo;
            check($sformatf("rxv_pulses_%0d", k), 32'(rxv_cnt[k] - rv0), 1);
            check($sformatf("rxdata_%0d", k), 32'(rx_data[k]), 32'(mo));
            check($sformatf("miso_word_%0d", k), 32'(sin), 32'(exp_miso));
        end
        check($sformatf("underrun_%0d", k), 32'(unr_cnt[k] - un0),
              32'(exp_unr));
        check($sformatf("busy_off_%0d", k), 32'(busy[k]), 0);
        check($sformatf("txrdy_end_%0d", k), 32'(tx_ready[k]),
              32'(!m_full[k]));
    endtask

    initial begin
        int          k, nb;
        logic [W-1:0] d;
        for (int j = 0; j < N; j++) begin
            sck[j]      = ((j % 4) / 2) != 0;
            cs[j]       = 1'b1;
            mosi[j]     = 1'b0;
            tx_valid[j] = 1'b0;
            tx_data[j]  = '0;
            m_full[j]   = 1'b0;
            m_hold[j]   = '0;
            m_rx[j]     = '0;
            rxv_cnt[j]  = 0;
            unr_cnt[j]  = 0;
        end
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        for (int j = 0; j < N; j++) check_reset_vals(j, "rst");
        rst_n = 1'b1;
        repeat (10) @(negedge clk);

        push(0, 12'h3C3);
        frame(0, 12'hA5A, W, 1'b0);

        push(4, 12'h3C3);
        frame(4, 12'hA5A, W, 1'b0);

        for (int j = 1; j < 4; j++) begin
            push(j, 12'h801);
            frame(j, 12'h801, W, 1'b0);
        end

        frame(0, 12'h5A5, W, 1'b0);

        push(0, 12'h123);
        frame(0, 12'hABC, 5, 1'b0);
        push(0, 12'h456);
        frame(0, 12'h0F0, W, 1'b0);

        push(1, 12'h111);
        push(1, 12'h222);
        frame(1, 12'h333, W, 1'b0);

        push(2, 12'h456);
        frame(2, 12'h777, W, 1'b1);
        repeat (5) @(negedge clk);
        frame(2, 12'h0F0, W, 1'b0);

        repeat (25) begin
            k = $urandom_range(0, N - 1);
            if ($urandom_range(0, 1) == 1) begin
                d = W'($urandom);
                push(k, d);
                if ($urandom_range(0, 3) == 0) begin
                    d = W'($urandom);
                    push(k, d);
                end
            end
            nb = ($urandom_range(0, 4) == 0) ? $urandom_range(1, W - 1) : W;
            d  = W'($urandom);
            frame(k, d, nb, 1'b0);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
